// File: rtl/bin2bcd_stream_pkg.sv
// Shared types and helpers for the streaming binary-to-BCD converter.
// Holds the FSM state encoding, the digit add-3 step and a digit-count helper.
package bin2bcd_stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [3:0] bcd_adj3(input logic [3:0] digit);
        return (digit >= 4'd5) ? digit + 4'd3 : digit;
    endfunction

    // Decimal digits of 2^bin_w - 1, i.e. ceil(bin_w * log10(2)) for bin_w >= 1.
    function automatic int dec_digits_min(input int bin_w);
        return (bin_w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bin2bcd_stream_dig.sv
// One BCD digit of the shift-and-add-3 chain: adjust, shift left, pass the
// adjusted MSB up to the next digit.
module bcd_shift_dig
    import bin2bcd_stream_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       shift,
    input  logic       shift_in,
    output logic [3:0] digit,
    output logic       carry_out
);

    logic [3:0] adj;

    assign adj       = bcd_adj3(digit);
    assign carry_out = adj[3];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit <= 4'd0;
        end else if (clear) begin
            digit <= 4'd0;
        end else if (shift) begin
            digit <= {adj[2:0], shift_in};
        end
    end

endmodule

// File: rtl/bin2bcd_stream.sv
// Streaming binary-to-BCD converter: one BIN_W-cycle shift-and-add-3 pass per
// transaction, signed input support, sticky overflow and significant-digit count.
//
// state | meaning
// IDLE  | ready for a new value (in_ready=1)
// CONV  | BIN_W shift-and-add-3 steps in progress
// DONE  | result presented, held until out_ready
module bin2bcd_stream
    import bin2bcd_stream_pkg::*;
#(
    parameter int BIN_W     = 32,
    parameter int DEC_W     = 10,
    parameter int SIGNED_EN = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [BIN_W-1:0]             in_data,
    input  logic                         in_signed,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [DEC_W-1:0][3:0]        out_bcd,
    output logic                         out_neg,
    output logic                         out_ovf,
    output logic [$clog2(DEC_W+1)-1:0]   out_digits,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int   CNT_W    = $clog2(BIN_W);
    localparam int   DIG_W    = $clog2(DEC_W+1);
    localparam logic SIGNED_B = (SIGNED_EN != 0);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [BIN_W-1:0]   mag;
    logic [BIN_W-1:0]   mag_in;
    logic               neg;
    logic               neg_raw;
    logic               neg_in;
    logic               ovf;
    logic               accept;
    logic               shift;
    logic [DEC_W:0]     carry;

    assign neg_raw = in_signed & SIGNED_B & in_data[BIN_W-1];
    assign mag_in  = neg_raw ? (~in_data + BIN_W'(1)) : in_data;
    // A zero magnitude is never reported as negative.
    assign neg_in  = neg_raw & (|mag_in);

    assign accept  = in_valid & in_ready;
    assign shift   = (state == CONV);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            mag <= '0;
            neg <= 1'b0;
            ovf <= 1'b0;
        end else if (accept) begin
            cnt <= CNT_W'(BIN_W-1);
            mag <= mag_in;
            neg <= neg_in;
            ovf <= 1'b0;
        end else if (shift) begin
            cnt <= cnt - CNT_W'(1);
            mag <= {mag[BIN_W-2:0], 1'b0};
            if (carry[DEC_W]) begin
                ovf <= 1'b1;
            end
        end
    end

    assign carry[0] = mag[BIN_W-1];

    // The carry out of the top digit is dropped, so the digits hold magnitude mod 10^DEC_W.
    for (genvar i = 0; i < DEC_W; i++) begin : g_dig
        bcd_shift_dig u_dig (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear     (accept),
            .shift     (shift),
            .shift_in  (carry[i]),
            .digit     (out_bcd[i]),
            .carry_out (carry[i+1])
        );
    end

    assign out_neg = neg;
    assign out_ovf = ovf;

    always_comb begin
        out_digits = DIG_W'(1);
        for (int i = 0; i < DEC_W; i++) begin
            if (out_bcd[i] != 4'd0) begin
                out_digits = DIG_W'(i + 1);
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_stream.sv
// Bench for bin2bcd_stream: DEC_W=5 and DEC_W=4 instances driven in lockstep
// from a vector table through a scoreboard queue, plus backpressure and reset sequences.
module tb_bin2bcd_stream;

    typedef struct {
        logic [15:0] data;
        logic        sgn;
        logic        neg;
        logic [19:0] bcd5;
        logic [2:0]  dig5;
        logic        ovf5;
        logic [15:0] bcd4;
        logic [2:0]  dig4;
        logic        ovf4;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [15:0]    in_data;
    logic           in_signed;
    logic           in_valid;
    logic           out_ready;

    logic           in_ready5, out_valid5, out_neg5, out_ovf5;
    logic [4:0][3:0] bcd5;
    logic [2:0]     dig5;
    logic           in_ready4, out_valid4, out_neg4, out_ovf4;
    logic [3:0][3:0] bcd4;
    logic [2:0]     dig4;

    int   tests  = 0;
    int   failed = 0;
    vec_t exp_q[$];
    vec_t vecs[13];

    always #5 clk = ~clk;

    bin2bcd_stream #(.BIN_W(16), .DEC_W(5), .SIGNED_EN(1)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_signed(in_signed),
        .in_valid(in_valid), .in_ready(in_ready5), .out_bcd(bcd5),
        .out_neg(out_neg5), .out_ovf(out_ovf5), .out_digits(dig5),
        .out_valid(out_valid5), .out_ready(out_ready)
    );

    bin2bcd_stream #(.BIN_W(16), .DEC_W(4), .SIGNED_EN(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_signed(in_signed),
        .in_valid(in_valid), .in_ready(in_ready4), .out_bcd(bcd4),
        .out_neg(out_neg4), .out_ovf(out_ovf4), .out_digits(dig4),
        .out_valid(out_valid4), .out_ready(out_ready)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_result(input string tag, input vec_t e);
        chk({tag, "_bcd5"}, 32'(bcd5), 32'(e.bcd5));
        chk({tag, "_dig5"}, 32'(dig5), 32'(e.dig5));
        chk({tag, "_ovf5"}, 32'(out_ovf5), 32'(e.ovf5));
        chk({tag, "_neg5"}, 32'(out_neg5), 32'(e.neg));
        chk({tag, "_bcd4"}, 32'(bcd4), 32'(e.bcd4));
        chk({tag, "_dig4"}, 32'(dig4), 32'(e.dig4));
        chk({tag, "_ovf4"}, 32'(out_ovf4), 32'(e.ovf4));
        chk({tag, "_neg4"}, 32'(out_neg4), 32'(e.neg));
    endtask

    task automatic sb_pop_check(input string tag, output vec_t e);
        if (exp_q.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL %s_scoreboard actual=empty expected=entry", tag);
            e = vecs[0];
        end else begin
            e = exp_q.pop_front();
            chk_result(tag, e);
        end
    endtask

    // Present a vector, wait for acceptance; leaves the bench just after edge E0.
    task automatic accept_vec(input string tag, input vec_t v);
        int n;
        in_data   = v.data;
        in_signed = v.sgn;
        in_valid  = 1'b1;
        n = 0;
        while (!(in_ready5 && in_ready4) && n < 50) begin
            cycle();
            n++;
        end
        chk({tag, "_accept_wait"}, 32'(in_ready5 && in_ready4), 32'd1);
        exp_q.push_back(v);
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int   n;
        vec_t e;
        accept_vec(tag, v);
        n = 0;
        while (!(out_valid5 && out_valid4) && n < 100) begin
            cycle();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd16);
        out_ready = 1'b1;
        sb_pop_check(tag, e);
        cycle();
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(out_valid5 | out_valid4), 32'd0);
    endtask

    initial begin
        int   n;
        int   bad;
        vec_t v;
        vec_t e;

        //          data      sgn   neg   bcd5       d5    ovf5  bcd4      d4    ovf4
        vecs[0]  = '{16'h0000, 1'b0, 1'b0, 20'h00000, 3'd1, 1'b0, 16'h0000, 3'd1, 1'b0};
        vecs[1]  = '{16'hFFFF, 1'b0, 1'b0, 20'h65535, 3'd5, 1'b0, 16'h5535, 3'd4, 1'b1};
        vecs[2]  = '{16'h8000, 1'b0, 1'b0, 20'h32768, 3'd5, 1'b0, 16'h2768, 3'd4, 1'b1};
        vecs[3]  = '{16'h8000, 1'b1, 1'b1, 20'h32768, 3'd5, 1'b0, 16'h2768, 3'd4, 1'b1};
        vecs[4]  = '{16'hFFFF, 1'b1, 1'b1, 20'h00001, 3'd1, 1'b0, 16'h0001, 3'd1, 1'b0};
        vecs[5]  = '{16'h0000, 1'b1, 1'b0, 20'h00000, 3'd1, 1'b0, 16'h0000, 3'd1, 1'b0};
        vecs[6]  = '{16'h3039, 1'b0, 1'b0, 20'h12345, 3'd5, 1'b0, 16'h2345, 3'd4, 1'b1};
        vecs[7]  = '{16'h270F, 1'b0, 1'b0, 20'h09999, 3'd4, 1'b0, 16'h9999, 3'd4, 1'b0};
        vecs[8]  = '{16'h7FFF, 1'b1, 1'b0, 20'h32767, 3'd5, 1'b0, 16'h2767, 3'd4, 1'b1};
        vecs[9]  = '{16'hFB2E, 1'b1, 1'b1, 20'h01234, 3'd4, 1'b0, 16'h1234, 3'd4, 1'b0};
        vecs[10] = '{16'h2710, 1'b0, 1'b0, 20'h10000, 3'd5, 1'b0, 16'h0000, 3'd1, 1'b1};
        vecs[11] = '{16'h0007, 1'b0, 1'b0, 20'h00007, 3'd1, 1'b0, 16'h0007, 3'd1, 1'b0};
        vecs[12] = '{16'hD8F0, 1'b1, 1'b1, 20'h10000, 3'd5, 1'b0, 16'h0000, 3'd1, 1'b1};

        rst_n     = 1'b0;
        in_data   = 16'h0;
        in_signed = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cycle();
        cycle();

        chk("rst_in_ready_low", 32'(in_ready5 | in_ready4), 32'd0);
        chk("rst_out_valid", 32'(out_valid5 | out_valid4), 32'd0);
        chk("rst_bcd5", 32'(bcd5), 32'd0);
        chk("rst_dig5", 32'(dig5), 32'd1);
        chk("rst_neg_ovf", 32'({out_neg5, out_ovf5, out_neg4, out_ovf4}), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_release_in_ready", 32'(in_ready5 && in_ready4), 32'd1);
        cycle();

        for (int i = 0; i < 13; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure with in_valid pulsed throughout CONV and DONE.
        v = vecs[6];
        accept_vec("bp", v);
        in_data = 16'hAAAA;
        n = 0;
        bad = 0;
        while (!(out_valid5 && out_valid4) && n < 100) begin
            if (in_ready5 || in_ready4) bad++;
            in_valid = ~in_valid;
            cycle();
            n++;
        end
        chk("bp_latency", 32'(n), 32'd16);
        chk("bp_conv_in_ready", 32'(bad), 32'd0);
        sb_pop_check("bp_first", e);
        for (int i = 0; i < 10; i++) begin
            in_valid = ~in_valid;
            cycle();
            chk($sformatf("bp_hold%0d_valid", i), 32'(out_valid5 && out_valid4), 32'd1);
            chk($sformatf("bp_hold%0d_in_ready", i), 32'(in_ready5 | in_ready4), 32'd0);
            chk($sformatf("bp_hold%0d_bcd5", i), 32'(bcd5), 32'(v.bcd5));
            chk($sformatf("bp_hold%0d_bcd4", i), 32'(bcd4), 32'(v.bcd4));
            chk($sformatf("bp_hold%0d_flags", i), 32'({out_neg5, out_ovf5, dig5, out_ovf4, dig4}),
                32'({v.neg, v.ovf5, v.dig5, v.ovf4, v.dig4}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        chk("bp_release_valid", 32'(out_valid5 | out_valid4), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready5 && in_ready4), 32'd1);

        // Reset during CONV aborts the transaction.
        v = vecs[1];
        accept_vec("rst_mid", v);
        void'(exp_q.pop_back());
        repeat (4) cycle();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_in_ready_low", 32'(in_ready5 | in_ready4), 32'd0);
        cycle();
        rst_n = 1'b1;
        #1;
        chk("rst_mid_in_ready_after", 32'(in_ready5 && in_ready4), 32'd1);
        chk("rst_mid_bcd_clear", 32'({bcd5, dig5}), 32'({20'h0, 3'd1}));
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid5 || out_valid4) bad++;
            cycle();
        end
        chk("rst_mid_no_result", 32'(bad), 32'd0);
        run_vec("after_rst", '{16'd1234, 1'b0, 1'b0, 20'h01234, 3'd4, 1'b0, 16'h1234, 3'd4, 1'b0});

        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/bin2bcd_stream.md
# bin2bcd_stream

Iterative binary-to-BCD converter (shift-and-add-3) with valid/ready handshakes on both sides, per-transaction signed/unsigned mode, overflow detection when DEC_W is too small, and a significant-digit count for leading-zero blanking. It is the streaming, parametrised successor to the single-shot converter. It sits between arithmetic datapaths and display, UART or text formatters that consume decimal digits.

## Interface
- BIN_W, default 32: binary input width, at least 2.
- DEC_W, default 10: number of BCD digits, at least 1.
- SIGNED_EN, default 1: 1 enables signed mode; 0 forces in_signed to be treated as 0.
- clk  in  1  clock.
- rst_n  in  1  reset; **one clock; reset is synchronous and active-low**.
- in_data  in  BIN_W  binary value.
- in_signed  in  1  1 = interpret in_data as two's complement.
- in_valid  in  1  input valid.
- in_ready  out  1  block can accept input.
- out_bcd  out  DEC_W×4 (packed [DEC_W-1:0][3:0])  digits of the magnitude; digit 0 is least significant.
- out_neg  out  1  value was negative.
- out_ovf  out  1  magnitude ≥ 10^DEC_W.
- out_digits  out  $clog2(DEC_W+1)  count of significant digits, range 1..DEC_W.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.

## Operation
- FSM states:
  - IDLE: in_ready=1. In_valid & in_ready moves to CONV.
  - CONV: lasts exactly BIN_W cycles, then moves to DONE.
  - DONE: out_valid=1. Out_valid & out_ready moves to IDLE.
- Capture at accept:
  - neg = in_signed & SIGNED_EN & in_data[BIN_W-1].
  - Magnitude register = neg ? (~in_data + 1) : in_data, BIN_W bits unsigned.
  - The most negative value -2^(BIN_W-1) gives magnitude 2^(BIN_W-1), which is correct.
  - BCD register and ovf are cleared.
- Each CONV cycle:
  - Every digit ≥ 5 gets +3.
  - Digit vector shifts left one bit; magnitude MSB enters digit 0 bit 0; magnitude shifts left.
  - If bit 3 of digit DEC_W-1 after adjust is 1, ovf sets and stays set (sticky).
- On overflow, out_bcd holds magnitude mod 10^DEC_W.
- out_digits = index of the highest nonzero digit + 1. All-zero gives 1. Computed combinationally from out_bcd.
- Zero is never negative: a zero magnitude forces neg=0.
- in_valid in any state other than IDLE is ignored; in_ready=0 in those states.
- While out_valid=1 and out_ready=0, all out_* signals stay stable.

## Timing
- Accept on edge E0. CONV steps happen on E1..E_BIN_W. out_valid rises after E_BIN_W, so latency is BIN_W cycles.
- Out handshake in cycle k puts the FSM in IDLE at k+1. Next accept is possible at the earliest at k+1.
- Peak throughput is one result per BIN_W+2 cycles.
- out_ready may be high before out_valid; it has no effect outside DONE.
- Reset with rst_n=0 sampled at an edge:
  - state=IDLE, out_valid=0, out_bcd=0, out_neg=0, out_ovf=0, so out_digits=1.
  - in_ready=0 while rst_n=0, and 1 from the first cycle after release.
- Reset mid-CONV or mid-DONE aborts the transaction; no result is produced.

## Structure
- Package bin2bcd_stream_pkg:
  - state enum typedef (IDLE, CONV, DONE).
  - function bcd_adj3 (digit ≥ 5 ? digit+3 : digit).
  - function dec_digits_min(bin_w), returning the DEC_W needed for overflow-free unsigned operation.
- Sub-module bcd_shift_dig, one per digit:
  - Holds the 4-bit register, add-3 logic, shift-in bit and carry-out.
  - Has a load-clear input.
  - The FSM, negation, ovf flag and digit-count priority encoder stay in the top module.

## Test plan
All scenarios use BIN_W=16, DEC_W=5, SIGNED_EN=1 unless stated.
- Unsigned 0 -> bcd 00000, digits 1, neg 0, ovf 0; out_valid exactly 16 cycles after accept.
- Unsigned 65535 -> 65535, digits 5; unsigned 0x8000 -> 32768, neg 0.
- Signed 0x8000 -> neg 1, 32768; signed 0xFFFF -> neg 1, 00001, digits 1; signed 0x0000 -> neg 0.
- Instance with DEC_W=4, unsigned 12345 -> ovf 1, bcd 2345; 9999 -> ovf 0, digits 4.
- Backpressure, with in_valid pulsed during CONV and DONE:
  - out_ready held low 10 cycles -> outputs stable and in_ready 0 throughout.
  - Pulses ignored; the first out_ready-high cycle completes the handshake.
- Reset during CONV cycle 5 -> out_valid never asserts; in_ready is 1 after release; next input 1234 -> 01234, digits 4.
